// File: rtl/snn_lif_layer.sv
// Leaky integrate-and-fire spiking layer.
// N_IN input spike lines drive N_OUT neurons through a runtime-loadable signed
// weight table. Each time step serially accumulates one input per cycle into
// every neuron in parallel, then applies leak, saturation, threshold and a
// refractory hold in a single fire cycle.
module snn_lif_layer #(
    parameter int N_IN   = 16,
    parameter int N_OUT  = 8,
    parameter int W_W    = 4,
    parameter int V_W    = 12,
    parameter int REFRAC = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             step,
    input  logic [N_IN-1:0]                  in_spk,
    input  logic                             clr,
    input  logic                             w_we,
    input  logic [$clog2(N_OUT*N_IN)-1:0]    w_addr,
    input  logic [W_W-1:0]                   w_data,
    input  logic [V_W-1:0]                   thresh,
    input  logic [V_W-1:0]                   leak,
    output logic [N_OUT-1:0]                 out_spk,
    output logic                             out_valid,
    output logic                             busy
);

    localparam int A_W   = $clog2(N_OUT*N_IN);
    localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int RC_W  = (REFRAC > 0) ? $clog2(REFRAC+1) : 1;
    localparam int ACC_W = V_W + 2;
    localparam int S_W   = V_W + 3;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FIRE
    } state_t;

    state_t state, state_nx;

    logic [W_W-1:0]   w_mem   [N_OUT*N_IN];
    logic [V_W-1:0]   v       [N_OUT];
    logic [RC_W-1:0]  rc      [N_OUT];
    logic [ACC_W-1:0] acc     [N_OUT];
    logic [N_IN-1:0]  in_lat;
    logic [IW-1:0]    idx;

    logic [S_W-1:0]   s_sum   [N_OUT];
    logic [V_W-1:0]   v_clamp [N_OUT];
    logic [V_W-1:0]   v_nx    [N_OUT];
    logic [RC_W-1:0]  rc_nx   [N_OUT];
    logic [N_OUT-1:0] spk_nx;

    logic idle_ok;
    logic accept;

    // busy stays high through the out_valid cycle, so IDLE only acts once it drops
    assign idle_ok = (state == IDLE) && !busy;
    assign accept  = idle_ok && step;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic: IDLE -> ACC (N_IN cycles) -> FIRE -> IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ACC;
            ACC:     if (idx == IW'(N_IN-1)) state_nx = FIRE;
            FIRE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Fire evaluation: leak, accumulate, clamp, then threshold/refractory per neuron
    always_comb begin
        spk_nx = '0;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            s_sum[j] = {{(S_W-V_W){1'b0}}, v[j]} - {{(S_W-V_W){1'b0}}, leak}
                     + {acc[j][ACC_W-1], acc[j]};
            if (s_sum[j][S_W-1])              v_clamp[j] = '0;
            else if (|s_sum[j][S_W-2:V_W])    v_clamp[j] = '1;
            else                              v_clamp[j] = s_sum[j][V_W-1:0];
            v_nx[j]  = v_clamp[j];
            rc_nx[j] = rc[j];
            if (rc[j] != '0) begin
                v_nx[j]  = '0;
                rc_nx[j] = rc[j] - RC_W'(1);
            end else if (v_clamp[j] >= thresh) begin
                spk_nx[j] = 1'b1;
                v_nx[j]   = '0;
                rc_nx[j]  = RC_W'(REFRAC);
            end
        end
    end

    // Datapath: weight table, step latch, serial accumulation, membrane update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < N_OUT*N_IN; k++) w_mem[k] <= '0;
            for (int unsigned j = 0; j < N_OUT; j++) begin
                v[j]   <= '0;
                rc[j]  <= '0;
                acc[j] <= '0;
            end
            in_lat    <= '0;
            idx       <= '0;
            out_spk   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (out_valid) busy <= 1'b0;
                    if (accept) begin
                        in_lat <= in_spk;
                        idx    <= '0;
                        busy   <= 1'b1;
                        for (int unsigned j = 0; j < N_OUT; j++) acc[j] <= '0;
                    end else if (idle_ok && clr) begin
                        for (int unsigned j = 0; j < N_OUT; j++) begin
                            v[j]  <= '0;
                            rc[j] <= '0;
                        end
                    end
                    if (idle_ok && w_we && (int'(w_addr) < N_OUT*N_IN))
                        w_mem[w_addr] <= w_data;
                end
                ACC: begin
                    if (in_lat[idx]) begin
                        for (int unsigned j = 0; j < N_OUT; j++)
                            acc[j] <= acc[j]
                                + {{(ACC_W-W_W){w_mem[A_W'(j*N_IN + 32'(idx))][W_W-1]}},
                                   w_mem[A_W'(j*N_IN + 32'(idx))]};
                    end
                    idx <= idx + IW'(1);
                end
                FIRE: begin
                    for (int unsigned j = 0; j < N_OUT; j++) begin
                        v[j]  <= v_nx[j];
                        rc[j] <= rc_nx[j];
                    end
                    out_spk   <= spk_nx;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_lif_layer.sv
// Directed testbench for snn_lif_layer. Two instances share all inputs:
// dut0 has no refractory period, dut2 has a 2-step refractory period.
module tb_snn_lif_layer;

    logic        clk = 1'b0;
    logic        reset, step, clr, w_we;
    logic [15:0] in_spk;
    logic [6:0]  w_addr;
    logic [3:0]  w_data;
    logic [11:0] thresh, leak;
    logic [7:0]  out_spk0, out_spk2;
    logic        out_valid0, out_valid2, busy0, busy2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    snn_lif_layer #(.N_IN(16), .N_OUT(8), .W_W(4), .V_W(12), .REFRAC(0)) dut0 (
        .clk(clk), .reset(reset), .step(step), .in_spk(in_spk), .clr(clr),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .thresh(thresh), .leak(leak),
        .out_spk(out_spk0), .out_valid(out_valid0), .busy(busy0)
    );

    snn_lif_layer #(.N_IN(16), .N_OUT(8), .W_W(4), .V_W(12), .REFRAC(2)) dut2 (
        .clk(clk), .reset(reset), .step(step), .in_spk(in_spk), .clr(clr),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .thresh(thresh), .leak(leak),
        .out_spk(out_spk2), .out_valid(out_valid2), .busy(busy2)
    );

    task automatic do_reset;
        reset = 1'b1; step = 1'b0; clr = 1'b0; w_we = 1'b0;
        in_spk = '0; w_addr = '0; w_data = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic write_w(input int j, input int i, input logic [3:0] d);
        w_we = 1'b1; w_addr = 7'(j*16 + i); w_data = d;
        @(posedge clk); #1;
        w_we = 1'b0;
    endtask

    // Runs one step from an idle cycle; returns cycles to out_valid (-1 on timeout),
    // the captured spike vectors and the number of busy cycles. Ends one cycle after valid.
    task automatic do_step(input logic [15:0] spk, output int lat,
                           output logic [7:0] o0, output logic [7:0] o2, output int bcnt);
        lat = -1; bcnt = 0; o0 = 'x; o2 = 'x;
        step = 1'b1; in_spk = spk;
        @(posedge clk); #1;
        step = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (busy0) bcnt++;
            if (out_valid0 && lat < 0) begin
                lat = c; o0 = out_spk0; o2 = out_spk2;
            end
            if (lat >= 0 && !busy0) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        checks++; if (out_spk0 !== 8'h00) begin failures++; $display("FAIL reset_spk0: got %h expected 00", out_spk0); end
        checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL reset_valid0: got %b expected 0", out_valid0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy0: got %b expected 0", busy0); end
        checks++; if (out_spk2 !== 8'h00) begin failures++; $display("FAIL reset_spk2: got %h expected 00", out_spk2); end
        checks++; if (out_valid2 !== 1'b0) begin failures++; $display("FAIL reset_valid2: got %b expected 0", out_valid2); end
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy2: got %b expected 0", busy2); end
    endtask

    task automatic test_reset_mid_acc;
        int lat, b, pulses;
        logic [7:0] o0, o2;
        do_reset;
        thresh = '0; leak = '0;
        do_step(16'h0001, lat, o0, o2, b);
        checks++; if (o0 !== 8'hFF) begin failures++; $display("FAIL midrst_pre_spk: got %h expected ff", o0); end
        step = 1'b1; in_spk = 16'h0001;
        @(posedge clk); #1;
        step = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1; #1;
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy0); end
        checks++; if (out_spk0 !== 8'h00) begin failures++; $display("FAIL midrst_spk: got %h expected 00", out_spk0); end
        checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b expected 0", out_valid0); end
        @(posedge clk); #1;
        reset = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid0 || out_valid2) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL midrst_no_valid: got %0d pulses expected 0", pulses); end
        do_step(16'h0001, lat, o0, o2, b);
        checks++; if (lat != 18) begin failures++; $display("FAIL midrst_next_lat: got %0d expected 18", lat); end
        checks++; if (o0 !== 8'hFF) begin failures++; $display("FAIL midrst_next_spk0: got %h expected ff", o0); end
        checks++; if (o2 !== 8'hFF) begin failures++; $display("FAIL midrst_next_spk2: got %h expected ff", o2); end
    endtask

    task automatic test_basic;
        int lat, b;
        logic [7:0] o0, o2;
        logic [7:0] e0 [3] = '{8'h00, 8'h01, 8'h00};
        do_reset;
        thresh = 12'd10; leak = '0;
        write_w(0, 0, 4'd5);
        for (int k = 0; k < 3; k++) begin
            do_step(16'h0001, lat, o0, o2, b);
            checks++; if (o0 !== e0[k]) begin failures++; $display("FAIL basic_spk[%0d]: got %h expected %h", k, o0, e0[k]); end
            checks++; if (lat != 18) begin failures++; $display("FAIL basic_lat[%0d]: got %0d expected 18", k, lat); end
            checks++; if (b != 18) begin failures++; $display("FAIL basic_busy[%0d]: got %0d expected 18", k, b); end
        end
    endtask

    task automatic test_refrac;
        int lat, b;
        logic [7:0] o0, o2;
        logic [7:0] e2 [5] = '{8'h02, 8'h00, 8'h00, 8'h02, 8'h00};
        do_reset;
        thresh = 12'd7; leak = '0;
        write_w(1, 3, 4'd7);
        for (int k = 0; k < 5; k++) begin
            do_step(16'h0008, lat, o0, o2, b);
            checks++; if (o2 !== e2[k]) begin failures++; $display("FAIL refrac_spk2[%0d]: got %h expected %h", k, o2, e2[k]); end
            checks++; if (o0 !== 8'h02) begin failures++; $display("FAIL refrac_spk0[%0d]: got %h expected 02", k, o0); end
        end
    endtask

    task automatic test_saturate;
        int lat, b, first;
        logic [7:0] o0, o2;
        do_reset;
        thresh = 12'd4095; leak = '0;
        for (int i = 0; i < 16; i++) write_w(2, i, 4'h8);
        for (int k = 0; k < 2; k++) begin
            do_step(16'hFFFF, lat, o0, o2, b);
            checks++; if (o0 !== 8'h00) begin failures++; $display("FAIL sat_floor[%0d]: got %h expected 00", k, o0); end
        end
        for (int i = 0; i < 16; i++) write_w(2, i, 4'h7);
        first = 0;
        for (int k = 1; k <= 40; k++) begin
            do_step(16'hFFFF, lat, o0, o2, b);
            if (first == 0 && o0[2] === 1'b1) first = k;
            if (k == 36) begin
                checks++; if (o0 !== 8'h00) begin failures++; $display("FAIL sat_step36: got %h expected 00", o0); end
            end
            if (k == 37) begin
                checks++; if (o0 !== 8'h04) begin failures++; $display("FAIL sat_step37: got %h expected 04", o0); end
            end
            if (k == 38) begin
                checks++; if (o0 !== 8'h00) begin failures++; $display("FAIL sat_step38: got %h expected 00", o0); end
            end
        end
        checks++; if (first != 37) begin failures++; $display("FAIL sat_first_fire: got step %0d expected 37", first); end
    endtask

    task automatic test_leak;
        int lat, b;
        logic [7:0] o0, o2;
        do_reset;
        leak = 12'd3; thresh = 12'd100;
        write_w(4, 0, 4'd2);
        for (int k = 0; k < 3; k++) begin
            do_step(16'h0001, lat, o0, o2, b);
            checks++; if (o0 !== 8'h00) begin failures++; $display("FAIL leak_hold[%0d]: got %h expected 00", k, o0); end
        end
        leak = '0; thresh = 12'd3;
        do_step(16'h0001, lat, o0, o2, b);
        checks++; if (o0 !== 8'h00) begin failures++; $display("FAIL leak_v2: got %h expected 00", o0); end
        do_step(16'h0001, lat, o0, o2, b);
        checks++; if (o0 !== 8'h10) begin failures++; $display("FAIL leak_v4_fire: got %h expected 10", o0); end
    endtask

    task automatic test_busy_ignore;
        int lat, b, pulses, vcyc;
        logic [7:0] o0, o2, ov;
        do_reset;
        thresh = 12'd11; leak = '0;
        write_w(0, 0, 4'd5);
        do_step(16'h0001, lat, o0, o2, b);
        checks++; if (o0 !== 8'h00) begin failures++; $display("FAIL busy_pre: got %h expected 00", o0); end
        step = 1'b1; in_spk = 16'h0001;
        @(posedge clk); #1;
        step = 1'b0;
        pulses = 0; vcyc = -1; ov = 'x;
        for (int c = 1; c <= 40; c++) begin
            step = 1'b0; clr = 1'b0; w_we = 1'b0;
            if (c == 3)  begin w_we = 1'b1; w_addr = 7'd0; w_data = 4'h8; end
            if (c == 6)  clr = 1'b1;
            if (c == 8)  step = 1'b1;
            if (c == 18) begin step = 1'b1; clr = 1'b1; w_we = 1'b1; w_addr = 7'd0; w_data = 4'h8; end
            if (out_valid0) begin
                pulses++;
                if (vcyc < 0) begin vcyc = c; ov = out_spk0; end
            end
            @(posedge clk); #1;
        end
        step = 1'b0; clr = 1'b0; w_we = 1'b0;
        checks++; if (pulses != 1) begin failures++; $display("FAIL busy_pulses: got %0d expected 1", pulses); end
        checks++; if (vcyc != 18) begin failures++; $display("FAIL busy_valid_cycle: got %0d expected 18", vcyc); end
        checks++; if (ov !== 8'h00) begin failures++; $display("FAIL busy_spk: got %h expected 00", ov); end
        do_step(16'h0001, lat, o0, o2, b);
        checks++; if (o0 !== 8'h01) begin failures++; $display("FAIL busy_post_fire: got %h expected 01", o0); end
        checks++; if (lat != 18) begin failures++; $display("FAIL busy_post_lat: got %0d expected 18", lat); end
    endtask

    task automatic test_clear;
        int lat, b;
        logic [7:0] o0, o2;
        logic [7:0] e0 [3] = '{8'h00, 8'h00, 8'h01};
        // membranes are 0 after the previous fire; build v[0]=10 then clear
        do_step(16'h0001, lat, o0, o2, b);
        do_step(16'h0001, lat, o0, o2, b);
        checks++; if (o0 !== 8'h00) begin failures++; $display("FAIL clr_build: got %h expected 00", o0); end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_step(16'h0001, lat, o0, o2, b);
            checks++; if (o0 !== e0[k]) begin failures++; $display("FAIL clr_after[%0d]: got %h expected %h", k, o0, e0[k]); end
        end
    endtask

    initial begin
        reset = 1'b1; step = 1'b0; clr = 1'b0; w_we = 1'b0;
        in_spk = '0; w_addr = '0; w_data = '0; thresh = '0; leak = '0;
        #2;
        test_reset;
        @(posedge clk); #1;
        reset = 1'b0;
        test_reset_mid_acc;
        test_basic;
        test_refrac;
        test_saturate;
        test_leak;
        test_busy_ignore;
        test_clear;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
